// File: rtl/interrupt_ctrl.sv
// rtl/interrupt_ctrl.sv - two-source interrupt controller sequencing fetch interrupt entry and return
// Edge-detects key/eth requests, arbitrates eth-first, issues one pulse per take, tracks the handler until rti.
module interrupt_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_req,
    input  logic       eth_req,
    input  logic       int_en,
    input  logic [1:0] mask,
    input  logic       branch,
    input  logic       hold,
    input  logic       rti,
    output logic       interrupt_key,
    output logic       interrupt_eth,
    output logic       in_isr,
    output logic [1:0] active_src,
    output logic [1:0] pending,
    output logic       spurious_rti
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_SERVICE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_prev_req;
    logic [1:0] r_pending;
    logic [1:0] r_active;
    logic       r_spurious;
    logic [1:0] w_req;
    logic [1:0] w_event;
    logic [1:0] w_eligible;
    logic [1:0] w_winner;
    logic [1:0] w_clr;
    logic       w_take;

    assign w_req      = {eth_req, key_req};
    assign w_event    = w_req & ~r_prev_req;
    assign w_eligible = r_pending & ~mask;
    assign w_take     = (r_state == S_IDLE) & int_en & (|w_eligible) & ~branch & ~hold & ~rti;
    assign w_winner   = w_eligible[1] ? 2'b10 : 2'b01;
    assign w_clr      = w_take ? w_winner : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_take) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_SERVICE;
            S_SERVICE: if (rti) w_next = S_DRAIN;
            S_DRAIN:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Reset loads prev_req from the live request so a level held across reset is not an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_req <= w_req;
            r_pending  <= 2'b00;
            r_active   <= 2'b00;
            r_spurious <= 1'b0;
        end else begin
            r_prev_req <= w_req;
            r_pending  <= (r_pending & ~w_clr) | w_event;
            if (w_take) begin
                r_active <= w_winner;
            end else if (r_state == S_DRAIN) begin
                r_active <= 2'b00;
            end
            if (rti && (r_state != S_SERVICE)) begin
                r_spurious <= 1'b1;
            end
        end
    end

    always_comb begin
        interrupt_key = (r_state == S_ISSUE) & r_active[0];
        interrupt_eth = (r_state == S_ISSUE) & r_active[1];
        in_isr        = (r_state != S_IDLE);
        active_src    = r_active;
        pending       = r_pending;
        spurious_rti  = r_spurious;
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb/tb_interrupt_ctrl.sv - directed vector table plus randomized run against a reference model
module tb_interrupt_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_req = 1'b0;
    logic       eth_req = 1'b0;
    logic       int_en = 1'b0;
    logic [1:0] mask = 2'b00;
    logic       branch = 1'b0;
    logic       hold = 1'b0;
    logic       rti = 1'b0;
    logic       interrupt_key;
    logic       interrupt_eth;
    logic       in_isr;
    logic [1:0] active_src;
    logic [1:0] pending;
    logic       spurious_rti;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    interrupt_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .key_req       (key_req),
        .eth_req       (eth_req),
        .int_en        (int_en),
        .mask          (mask),
        .branch        (branch),
        .hold          (hold),
        .rti           (rti),
        .interrupt_key (interrupt_key),
        .interrupt_eth (interrupt_eth),
        .in_isr        (in_isr),
        .active_src    (active_src),
        .pending       (pending),
        .spurious_rti  (spurious_rti)
    );

    typedef struct {
        logic       rst, key, eth, en;
        logic [1:0] mask;
        logic       br, hd, rti;
        logic       ik, ie, isr;
        logic [1:0] act, pend;
        logic       spur;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, k, e, input logic [1:0] m, input logic b, h, t,
                       input logic ik, ie, isr, input logic [1:0] act, pend, input logic spur);
        vec_t v;
        v.rst = r; v.key = k; v.eth = e; v.en = 1'b1; v.mask = m;
        v.br = b; v.hd = h; v.rti = t;
        v.ik = ik; v.ie = ie; v.isr = isr; v.act = act; v.pend = pend; v.spur = spur;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    task automatic check_outs(input string tag, input logic ik, ie, isr,
                              input logic [1:0] act, pend, input logic spur);
        chk({tag, " interrupt_key"}, {1'b0, interrupt_key}, {1'b0, ik});
        chk({tag, " interrupt_eth"}, {1'b0, interrupt_eth}, {1'b0, ie});
        chk({tag, " in_isr"},        {1'b0, in_isr},        {1'b0, isr});
        chk({tag, " active_src"},    active_src,            act);
        chk({tag, " pending"},       pending,               pend);
        chk({tag, " spurious_rti"},  {1'b0, spurious_rti},  {1'b0, spur});
    endtask

    // Reference model: per-source pending flags, the serviced source index, and handler phase flags.
    bit m_prev[2];
    bit m_pend[2];
    bit m_spur, m_fresh, m_wait, m_drain;
    int m_src;

    task automatic model_step();
        bit req[2];
        bit ev[2];
        int win;
        req[0] = key_req;
        req[1] = eth_req;
        if (rst) begin
            for (int s = 0; s < 2; s++) begin m_prev[s] = req[s]; m_pend[s] = 0; end
            m_spur = 0; m_fresh = 0; m_wait = 0; m_drain = 0; m_src = -1;
            return;
        end
        for (int s = 0; s < 2; s++) begin
            ev[s] = req[s] && !m_prev[s];
            m_prev[s] = req[s];
        end
        if (rti && !m_wait) m_spur = 1;
        if (m_fresh) begin
            m_fresh = 0; m_wait = 1;
        end else if (m_wait) begin
            if (rti) begin m_wait = 0; m_drain = 1; end
        end else if (m_drain) begin
            m_drain = 0; m_src = -1;
        end else begin
            win = -1;
            for (int s = 0; s < 2; s++) if (m_pend[s] && !mask[s]) win = s;
            if (int_en && win >= 0 && !branch && !hold && !rti) begin
                m_pend[win] = 0; m_src = win; m_fresh = 1;
            end
        end
        for (int s = 0; s < 2; s++) if (ev[s]) m_pend[s] = 1;
    endtask

    task automatic check_model(input int cyc);
        logic [1:0] act;
        act = (m_src < 0) ? 2'b00 : ((m_src == 1) ? 2'b10 : 2'b01);
        check_outs($sformatf("rnd%0d", cyc), m_fresh && m_src == 0, m_fresh && m_src == 1,
                   m_fresh || m_wait || m_drain, act, {m_pend[1], m_pend[0]}, m_spur);
    endtask

    initial begin
        // rst key eth mask br hd rti | ik ie isr act pend spur
        add(0,0,0,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0); // 0
        add(0,0,0,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0);
        add(0,1,0,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0); // key rises
        add(0,1,0,2'b00,0,0,0, 0,0,0,2'b00,2'b01,0);
        add(0,1,0,2'b00,0,0,0, 1,0,1,2'b01,2'b00,0); // key pulse
        add(0,0,0,2'b00,0,0,0, 0,0,1,2'b01,2'b00,0); // 5
        add(0,0,0,2'b00,0,0,1, 0,0,1,2'b01,2'b00,0);
        add(0,0,0,2'b00,0,0,0, 0,0,1,2'b01,2'b00,0);
        add(0,0,0,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0);
        add(0,1,1,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0); // both rise
        add(0,1,1,2'b00,0,0,0, 0,0,0,2'b00,2'b11,0); // 10
        add(0,1,1,2'b00,0,0,0, 0,1,1,2'b10,2'b01,0); // eth first
        add(0,1,1,2'b00,0,0,0, 0,0,1,2'b10,2'b01,0);
        add(0,1,1,2'b00,0,0,1, 0,0,1,2'b10,2'b01,0);
        add(0,0,0,2'b00,0,0,0, 0,0,1,2'b10,2'b01,0);
        add(0,0,0,2'b00,0,0,0, 0,0,0,2'b00,2'b01,0); // 15
        add(0,0,0,2'b00,0,0,0, 1,0,1,2'b01,2'b00,0); // key 3 cycles after rti
        add(0,0,0,2'b00,0,0,1, 0,0,1,2'b01,2'b00,0);
        add(0,0,0,2'b00,0,0,0, 0,0,1,2'b01,2'b00,0);
        add(0,0,0,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0);
        add(0,0,1,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0); // 20 eth rises
        add(0,0,1,2'b00,1,0,0, 0,0,0,2'b00,2'b10,0);
        add(0,0,1,2'b00,1,0,0, 0,0,0,2'b00,2'b10,0);
        add(0,0,1,2'b00,0,1,0, 0,0,0,2'b00,2'b10,0);
        add(0,0,1,2'b00,0,0,0, 0,0,0,2'b00,2'b10,0);
        add(0,0,1,2'b00,0,0,0, 0,1,1,2'b10,2'b00,0); // 25 delayed 3
        add(0,0,1,2'b00,0,0,1, 0,0,1,2'b10,2'b00,0);
        add(0,0,0,2'b00,0,0,0, 0,0,1,2'b10,2'b00,0);
        add(0,0,0,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0);
        add(0,0,1,2'b10,0,0,0, 0,0,0,2'b00,2'b00,0); // masked eth rises
        add(0,0,1,2'b10,0,0,0, 0,0,0,2'b00,2'b10,0); // 30
        add(0,0,1,2'b10,0,0,0, 0,0,0,2'b00,2'b10,0);
        add(0,0,1,2'b00,0,0,0, 0,0,0,2'b00,2'b10,0); // unmask
        add(0,0,1,2'b00,0,0,0, 0,1,1,2'b10,2'b00,0);
        add(0,0,0,2'b00,0,0,1, 0,0,1,2'b10,2'b00,0);
        add(0,0,0,2'b00,0,0,0, 0,0,1,2'b10,2'b00,0); // 35
        add(0,0,0,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0);
        add(0,1,0,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0);
        add(0,1,0,2'b00,0,0,0, 0,0,0,2'b00,2'b01,0);
        add(0,0,0,2'b00,0,0,0, 1,0,1,2'b01,2'b00,0);
        add(0,1,0,2'b00,0,0,0, 0,0,1,2'b01,2'b00,0); // 40 re-raise in service
        add(0,1,0,2'b00,0,0,0, 0,0,1,2'b01,2'b01,0);
        add(0,1,0,2'b00,0,0,1, 0,0,1,2'b01,2'b01,0);
        add(0,1,0,2'b00,0,0,0, 0,0,1,2'b01,2'b01,0);
        add(0,1,0,2'b00,0,0,0, 0,0,0,2'b00,2'b01,0);
        add(0,0,0,2'b00,0,0,0, 1,0,1,2'b01,2'b00,0); // 45
        add(0,0,0,2'b00,0,0,1, 0,0,1,2'b01,2'b00,0);
        add(0,0,0,2'b00,0,0,0, 0,0,1,2'b01,2'b00,0);
        add(0,0,0,2'b00,0,0,1, 0,0,0,2'b00,2'b00,0); // rti in idle
        add(0,0,0,2'b00,0,0,0, 0,0,0,2'b00,2'b00,1);
        add(0,0,0,2'b00,0,0,0, 0,0,0,2'b00,2'b00,1); // 50
        add(1,0,1,2'b00,0,0,0, 0,0,0,2'b00,2'b00,1); // reset with eth high
        add(0,0,1,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0);
        add(0,0,1,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0);
        add(0,0,0,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0);
        add(0,0,1,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0); // 55
        add(0,0,1,2'b00,0,0,0, 0,0,0,2'b00,2'b10,0);
        add(0,0,0,2'b00,0,0,0, 0,1,1,2'b10,2'b00,0);
        add(0,1,0,2'b00,0,0,0, 0,0,1,2'b10,2'b00,0);
        add(0,1,0,2'b00,0,0,0, 0,0,1,2'b10,2'b01,0);
        add(1,1,0,2'b00,0,0,0, 0,0,1,2'b10,2'b01,0); // 60 reset in service
        add(0,1,0,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0);
        add(0,0,0,2'b00,0,0,0, 0,0,0,2'b00,2'b00,0);

        int_en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            rst = 1'b1;
        end
        @(negedge clk);
        check_outs("reset", 0, 0, 0, 2'b00, 2'b00, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (i > 0) @(negedge clk);
            check_outs($sformatf("row%0d", i), vecs[i].ik, vecs[i].ie, vecs[i].isr,
                       vecs[i].act, vecs[i].pend, vecs[i].spur);
            rst = vecs[i].rst; key_req = vecs[i].key; eth_req = vecs[i].eth;
            int_en = vecs[i].en; mask = vecs[i].mask;
            branch = vecs[i].br; hold = vecs[i].hd; rti = vecs[i].rti;
        end

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c > 0) check_model(c);
            rst     = (c < 2) || ($urandom_range(63) == 0);
            key_req = ($urandom_range(3) == 0) ? ~key_req : key_req;
            eth_req = ($urandom_range(3) == 0) ? ~eth_req : eth_req;
            int_en  = ($urandom_range(7) != 0);
            mask    = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
            branch  = ($urandom_range(3) == 0);
            hold    = ($urandom_range(4) == 0);
            rti     = ($urandom_range(5) == 0);
            model_step();
        end
        @(negedge clk);
        check_model(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Interrupt controller that sequences the fetch stage's interrupt entry and return. It edge-detects the keyboard and Ethernet interrupt requests, holds them as pending, and arbitrates between them with Ethernet taking priority. It issues exactly one `interrupt_key` or `interrupt_eth` pulse to fetch at a safe point, then tracks the handler until `rti`. It sits between the I/O peripherals / CSR enables and the fetch unit's interrupt inputs.

## Interface
Parameters:
- none (two fixed sources: bit 0 = key, bit 1 = eth)

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `key_req`  in  1  keyboard interrupt request; level, rising edge = one event
- `eth_req`  in  1  Ethernet interrupt request; level, rising edge = one event
- `int_en`  in  1  global interrupt enable (CSR)
- `mask`  in  2  per-source mask; 1 = blocked; [0] key, [1] eth
- `branch`  in  1  fetch redirect from EX this cycle
- `hold`  in  1  pipeline stall this cycle
- `rti`  in  1  return-from-interrupt decoded in EX this cycle
- `interrupt_key`  out  1  one-cycle pulse to fetch: take key interrupt
- `interrupt_eth`  out  1  one-cycle pulse to fetch: take eth interrupt
- `in_isr`  out  1  handler in progress
- `active_src`  out  2  one-hot source being serviced; 0 when idle
- `pending`  out  2  latched, not-yet-taken events
- `spurious_rti`  out  1  sticky error flag; set by an `rti` outside SERVICE

## Operation
- **Edge detect.** `prev_req[1:0]` is registered every cycle. During reset it loads the current `{eth_req,key_req}`, so a level held high across reset release is not an event. An event is `req & ~prev_req`.
- **Pending.** A bit is set on an event and cleared when that source is issued. If set and clear fall in the same cycle, set wins. A repeated event while the bit is already set is absorbed (no counting).
- **Take condition** (combinational, evaluated in IDLE only):
  - `int_en & |(pending & ~mask) & ~branch & ~hold & ~rti`.
  - Winner is eth if `pending[1] & ~mask[1]`, else key.
- **FSM states:** IDLE, ISSUE, SERVICE, DRAIN.
  - IDLE → ISSUE when the take condition holds. The winner's pending bit clears and `active_src` loads the winner one-hot.
  - ISSUE → SERVICE unconditionally after 1 cycle. `branch`, `hold` and `int_en` are ignored in ISSUE.
  - SERVICE → DRAIN on `rti`. `int_en` and `mask` changes have no effect in SERVICE.
  - DRAIN → IDLE unconditionally after 1 cycle, which lets the fetch redirect from `rti` settle.
- **Outputs** (all registered):
  - `interrupt_key` = ISSUE & `active_src[0]`.
  - `interrupt_eth` = ISSUE & `active_src[1]`.
  - `in_isr` = 1 in ISSUE, SERVICE and DRAIN.
  - `active_src` clears on entry to IDLE.
- **No nesting.** Events during ISSUE, SERVICE or DRAIN only set pending bits. They are taken after returning to IDLE.
- **Masked or disabled pending bits** stay set indefinitely and are taken once unmasked or enabled.
- **`rti` outside SERVICE** is ignored for state and sets `spurious_rti`. The flag clears only on `rst`.

## Timing
- **Reset values:** state = IDLE; `interrupt_key` = `interrupt_eth` = 0; `in_isr` = 0; `active_src` = 0; `pending` = 0; `spurious_rti` = 0.
- **Event latency:**
  - Request edge sampled at edge E → `pending` visible after E.
  - If the take condition holds in the next cycle, the pulse is high for the one cycle after edge E+1 (2 clocks from request rise to pulse).
- **Pulse width:** exactly 1 cycle, and never both pulses in the same cycle.
- **Return latency:**
  - `rti` in cycle N → DRAIN in N+1, IDLE in N+2.
  - The earliest next pulse is in cycle N+3. `in_isr` falls at the start of N+2.
- **Blocking:** `branch`, `hold` or `rti` high in an IDLE cycle defers the take by that cycle only. There is no extra penalty.
- **Reset mid-operation:** synchronous `rst` in any state returns everything to reset values on the next edge. Pending events are discarded and no pulse is emitted.

## Test plan
- Reset, then raise `key_req` at cycle 3 with `int_en`=1 and `mask`=0 → `pending`=01 in cycle 4, `interrupt_key`=1 in cycle 5 only, `in_isr`=1 from cycle 5, `active_src`=01.
- Raise `key_req` and `eth_req` in the same cycle → `interrupt_eth` first and `pending` stays 01. `rti` returns; 3 cycles after `rti`, `interrupt_key` pulses.
- Pending eth with `branch`=1 for 2 cycles then `hold`=1 for 1 cycle → pulse delayed exactly 3 cycles. With `mask`=10 it never pulses until `mask`=00, then it pulses 1 cycle later.
- Re-raise `key_req` during SERVICE of key → no pulse and `pending`=01. After `rti` → DRAIN, IDLE, then pulse. `rti` issued in IDLE → `spurious_rti`=1 and it stays 1.
- Hold `eth_req` high across `rst` release → no event and `pending`=00. Drop it and raise it again → normal issue.
- Assert `rst` in SERVICE → next cycle all outputs 0, state IDLE, and a pending key bit is cleared.
